fir_result_buffer: RTL and testbench
====================================

Name: fir_result_buffer

Overview:
Downstream stage of the FIR filter. Captures a frame of wide FIR accumulator results (93-bit, qualified by the filter's valid strobe) and rounds, scales and saturates each to a 16-bit signed sample. Writes samples sequentially into an internal 2048-deep sample buffer. Provides a registered random-access read port so the beamformer summation stage can fetch filtered samples by address.

Parameters:
IN_W, 93, width of FIR result input (signed two's complement)
OUT_W, 16, width of stored sample (signed)
SHIFT, 40, arithmetic right shift applied after rounding (must be >=1)
DEPTH, 2048, buffer depth in samples
ADDR_W, 11, address width, log2(DEPTH)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; arms a capture of frame_len samples
frame_len  input  ADDR_W+1  samples per frame, sampled on start; 0 means DEPTH
in_data  input  IN_W  FIR result
in_valid  input  1  in_data valid this cycle
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  OUT_W  read sample, valid when rd_valid=1
rd_valid  output  1  high one cycle after an accepted rd_en
busy  output  1  high in CAPTURE and FLUSH
done  output  1  high in DONE
sat_count  output  ADDR_W+1  samples saturated in current/last frame
drop_err  output  1  sticky: in_valid seen outside CAPTURE

Behaviour:
- Reset (rst=0, async): FSM=IDLE. rd_data=0, rd_valid=0, busy=0, done=0, sat_count=0, drop_err=0, write pointer=0, pipeline valids=0. Buffer contents are not cleared.
- FSM states: IDLE, CAPTURE, FLUSH, DONE.
- IDLE/DONE + start: latch frame_len (0 -> DEPTH), clear wr_ptr, sat_count and drop_err, go to CAPTURE.
- start in CAPTURE/FLUSH: ignored.
- CAPTURE: every cycle with in_valid=1 accepts one sample and increments the accepted count. When the accepted count reaches the latched length, go to FLUSH on the same edge. Further in_valid in FLUSH/DONE/IDLE is dropped and sets drop_err.
- Arithmetic pipeline, 2 stages:
  - S1 registers r = (in_data + 2^(SHIFT-1)) >>> SHIFT, full width, round-half-up.
  - S2 saturates r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], writes buf[wr_ptr], increments wr_ptr, and increments sat_count if clamped.
  - The buffer write occurs on the 2nd edge after acceptance.
- FLUSH: wait until both pipeline stages are empty, then go to DONE. done rises 3 edges after the edge that accepted the last sample.
- DONE: done=1 held until next start. wr_ptr does not wrap within a frame, since frame length is at most DEPTH.
- Read port:
  - rd_en accepted in IDLE and DONE only; ignored in CAPTURE/FLUSH (rd_valid stays 0).
  - Accepted read gives rd_data=buf[rd_addr] and rd_valid=1 on the next edge. rd_data holds its value when no read occurs.
  - Back-to-back reads sustain one per cycle.
  - Addresses beyond the last written sample return stale contents with no error.
- start and rd_en in the same cycle in DONE: start wins, read is not accepted.
- Reset mid-frame: immediate return to IDLE, partial frame is abandoned, done stays 0.

Test Plan:
- Rounding: frame_len=3, in_data = 3·2^40, 2^39, -2^39 -> after done, reads of addr 0,1,2 give 3, 1, 0; sat_count=0.
- Saturation: frame_len=2, in_data = 40000·2^40, -40000·2^40 -> reads give 32767, -32768; sat_count=2.
- Timing/gaps: frame_len=4, in_valid pattern 1,0,1,1,0,1 -> busy high from the edge after start; done rises exactly 3 edges after the 6th cycle's edge; reads return samples in acceptance order.
- frame_len=0: 2048 samples of value k·2^40 (k=0..2047, saturating above 32767) -> done after the 2048th; addr 2047 reads 2047; no extra write to addr 0.
- Protocol errors: in_valid while IDLE -> drop_err=1 and no write; start during CAPTURE ignored; rd_en during CAPTURE -> rd_valid stays 0; start with rd_en in DONE -> no rd_valid, new frame starts.
- Reset mid-frame: assert rst low after 2 of 5 samples -> all outputs 0 asynchronously; new start with frame_len=1 completes normally.

Source files
------------

// File: rtl/fir_result_buffer.sv
// -----------------------------------------------------------------------------
// fir_result_buffer
//
// Purpose:
//   Downstream stage of the FIR filter. Captures one frame of wide signed FIR
//   accumulator results, rounds each one (round-half-up), shifts it right
//   arithmetically, saturates it to a 16-bit signed sample and stores it in a
//   2048-deep buffer. A registered random-access read port lets the
//   beamformer summation stage fetch samples by address while no frame is
//   being captured.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   one-cycle pulse, arms a capture of frame_len samples
//   frame_len  in   samples per frame, sampled on start (0 means DEPTH)
//   in_data    in   FIR result, signed IN_W bits
//   in_valid   in   in_data valid this cycle
//   rd_en      in   read request
//   rd_addr    in   read address
//   rd_data    out  read sample, valid while rd_valid=1, held otherwise
//   rd_valid   out  high one cycle after an accepted read
//   busy       out  high in CAPTURE and FLUSH
//   done       out  high in DONE
//   sat_count  out  samples clamped in the current/last frame
//   drop_err   out  sticky, in_valid seen outside CAPTURE
//   dbg_state  out  current FSM state (debug visibility)
//
// Handshake: in_valid has no back-pressure; a sample is taken on every rising
// edge where in_valid=1 and the FSM is in CAPTURE. A read is taken on every
// rising edge where rd_en=1, the FSM is in IDLE or DONE and start is low; its
// result appears with rd_valid=1 after that edge.
// -----------------------------------------------------------------------------
module fir_result_buffer #(
  parameter int IN_W   = 93,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 40,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sat_count,
  output logic              drop_err,
  output logic [1:0]        dbg_state
);

  // Width of the rounded and shifted value. One guard bit above IN_W keeps
  // the rounding addition free of overflow.
  localparam int RW = IN_W + 1 - SHIFT;

  localparam logic [IN_W:0] ROUND_C =
    {{(IN_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

  localparam logic signed [RW-1:0] SAT_MAX = RW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   sat_cnt_q;
  logic              drop_q;

  // Stage 1: rounded and shifted value, full width.
  logic              s1_valid_q;
  logic [RW-1:0]     s1_q;

  // Stage 2: saturated sample ready to be written.
  logic              s2_valid_q;
  logic [OUT_W-1:0]  s2_q;
  logic              s2_sat_q;

  logic [OUT_W-1:0]  rd_data_q;
  logic              rd_valid_q;

  logic [OUT_W-1:0]  mem_q [DEPTH];

  logic              idle_or_done;
  logic              start_ok;
  logic              accept;
  logic              rd_ok;
  logic              last_sample;
  logic [IN_W:0]     round_sum;
  logic [RW-1:0]     rounded;
  logic              sat_hi;
  logic              sat_lo;
  logic [OUT_W-1:0]  sat_val;
  logic              unused_round_bits;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_ok     = start && idle_or_done;
  assign accept       = in_valid && (state_q == ST_CAPTURE);
  // start has priority over a read in the same cycle.
  assign rd_ok        = rd_en && idle_or_done && !start;
  assign last_sample  = accept && ((cnt_q + (ADDR_W + 1)'(1)) == len_q);

  // ---------------------------------------------------------------------------
  // Rounding: sign-extend by one bit, add half an LSB of the result, then the
  // arithmetic shift is simply taking the upper bits.
  // ---------------------------------------------------------------------------
  assign round_sum         = {in_data[IN_W-1], in_data} + ROUND_C;
  assign rounded           = round_sum[IN_W:SHIFT];
  assign unused_round_bits = ^round_sum[SHIFT-1:0];

  // ---------------------------------------------------------------------------
  // Saturation of stage 1 value to the signed OUT_W range
  // ---------------------------------------------------------------------------
  assign sat_hi = $signed(s1_q) > SAT_MAX;
  assign sat_lo = $signed(s1_q) < SAT_MIN;

  always_comb begin
    sat_val = s1_q[OUT_W-1:0];
    if (sat_hi) begin
      sat_val = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (sat_lo) begin
      sat_val = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_CAPTURE;
          len_d   = (frame_len == '0) ? DEPTH_LEN : frame_len;
          cnt_d   = '0;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          cnt_d = cnt_q + (ADDR_W + 1)'(1);
        end
        if (last_sample) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Wait for the last accepted sample to reach the buffer.
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic pipeline and write side
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_sat_q   <= 1'b0;
      wr_ptr_q   <= '0;
      sat_cnt_q  <= '0;
      drop_q     <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_q <= rounded;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_q     <= sat_val;
        s2_sat_q <= sat_hi || sat_lo;
      end

      // start is only honoured in IDLE/DONE, where the pipeline is empty, so
      // clearing here never races a pending write.
      if (start_ok) begin
        wr_ptr_q  <= '0;
        sat_cnt_q <= '0;
      end else if (s2_valid_q) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (s2_sat_q) begin
          sat_cnt_q <= sat_cnt_q + (ADDR_W + 1)'(1);
        end
      end

      if (start_ok) begin
        drop_q <= 1'b0;
      end else if (in_valid && (state_q != ST_CAPTURE)) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Sample storage is not reset; contents survive across frames and resets.
  always_ff @(posedge clk) begin
    if (s2_valid_q) begin
      mem_q[wr_ptr_q] <= s2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        rd_data_q <= mem_q[rd_addr];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign sat_count = sat_cnt_q;
  assign drop_err  = drop_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_fir_result_buffer
//
// Directed bench for fir_result_buffer. Each stored sample's expected value is
// recorded in a model array when it is driven; reads push that value onto
// exp_q and pop it when the read result appears.
// -----------------------------------------------------------------------------
module tb_fir_result_buffer;

  localparam int IN_W   = 93;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   frame_len;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [OUT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   sat_count;
  logic              drop_err;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] model [DEPTH];
  int               wp = 0;

  fir_result_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .sat_count (sat_count),
    .drop_err  (drop_err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k * 2^40 as a 93-bit two's complement value.
  function automatic logic [IN_W-1:0] mk(input int k);
    logic signed [IN_W-1:0] t;
    t = k;
    return t <<< 40;
  endfunction

  function automatic logic [OUT_W-1:0] clamp16(input int k);
    if (k > 32767) return 16'h7fff;
    if (k < -32768) return 16'h8000;
    return k[OUT_W-1:0];
  endfunction

  task automatic start_frame(input int len);
    start     = 1'b1;
    frame_len = len[ADDR_W:0];
    wp        = 0;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [OUT_W-1:0] e);
    in_valid  = 1'b1;
    in_data   = d;
    model[wp] = e;
    wp++;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  // Back-to-back reads of n consecutive addresses, then one idle cycle to
  // confirm the last result is held.
  task automatic read_burst(input int base, input int n, input string tag);
    logic [OUT_W-1:0] last;
    last = '0;
    for (int i = 0; i < n; i++) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(base + i);
      exp_q.push_back(model[base + i]);
      tick();
      chk({tag, "_rd_valid"}, rd_valid, 1);
      last = exp_q.pop_front();
      chk({tag, "_rd_data"}, rd_data, last);
    end
    rd_en = 1'b0;
    tick();
    chk({tag, "_rd_idle_valid"}, rd_valid, 0);
    chk({tag, "_rd_hold"}, rd_data, last);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [IN_W-1:0] half;
    logic [5:0]      pat;
    int              k;

    half      = '0;
    half[39]  = 1'b1;
    pat       = 6'b101101;
    rst       = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat_count", sat_count, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b1;
    tick();

    // in_valid while IDLE is dropped
    in_valid = 1'b1;
    in_data  = mk(5);
    tick();
    in_valid = 1'b0;
    chk("idle_drop_err", drop_err, 1);
    chk("idle_stays_idle", dbg_state, 0);

    // Rounding frame; start during CAPTURE and rd_en during CAPTURE ignored
    start_frame(3);
    chk("rnd_busy", busy, 1);
    chk("rnd_drop_cleared", drop_err, 0);
    send(mk(3), 16'd3);
    start     = 1'b1;
    frame_len = 12'd1;
    send(half, 16'd1);
    start     = 1'b0;
    chk("rnd_start_ignored", busy, 1);
    rd_en   = 1'b1;
    rd_addr = '0;
    send(-half, 16'd0);
    rd_en = 1'b0;
    chk("rnd_rd_in_capture", rd_valid, 0);
    chk("rnd_flush_state", dbg_state, 2);
    wait_done(10);
    chk("rnd_sat_count", sat_count, 0);
    read_burst(0, 3, "rnd");

    // Saturation frame
    start_frame(2);
    send(mk(40000), 16'h7fff);
    send(mk(-40000), 16'h8000);
    wait_done(10);
    chk("sat_sat_count", sat_count, 2);
    read_burst(0, 2, "sat");

    // Gapped input, exact done timing
    start_frame(4);
    chk("gap_busy", busy, 1);
    k = 10;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i];
      in_data  = mk(k);
      if (pat[i]) begin
        model[wp] = clamp16(k);
        wp++;
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("gap_done_e0", done, 0);
    chk("gap_busy_e0", busy, 1);
    tick();
    chk("gap_done_e1", done, 0);
    tick();
    chk("gap_done_e2", done, 0);
    tick();
    chk("gap_done_e3", done, 1);
    chk("gap_busy_e3", busy, 0);
    read_burst(0, 4, "gap");

    // start together with rd_en in DONE: start wins
    start     = 1'b1;
    frame_len = 12'd1;
    rd_en     = 1'b1;
    rd_addr   = 11'd2;
    wp        = 0;
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    chk("sr_no_rd_valid", rd_valid, 0);
    chk("sr_busy", busy, 1);
    send(mk(77), 16'd77);
    wait_done(10);
    read_burst(0, 1, "sr");

    // Reset in the middle of a frame
    start_frame(5);
    send(mk(-7), 16'hfff9);
    send(mk(8), 16'd8);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_state", dbg_state, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    chk("mid_rst_drop_err", drop_err, 0);
    tick();
    chk("mid_rst_done_held", done, 0);
    rst = 1'b1;
    tick();
    start_frame(1);
    send(mk(5), 16'd5);
    wait_done(10);
    read_burst(0, 1, "after_rst");

    // Full-depth frame (frame_len = 0)
    start_frame(0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        chk("full_busy_before_last", busy, 1);
        chk("full_not_done_early", done, 0);
      end
      send(mk(i), clamp16(i));
    end
    wait_done(10);
    chk("full_sat_count", sat_count, 0);
    read_burst(DEPTH - 1, 1, "full_last");
    read_burst(0, 2, "full_first");
    read_burst(1000, 1, "full_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
